// File: rtl/vm_multi_cal_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vm_multi_cal_if
//  Description : Host RAM port, vector stream input and result output bundle
//                for the multi-channel eigen dot-product calculator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vm_multi_cal_if #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 4
);
    // Host RAM port
    logic                     host_en;
    logic                     host_wren;
    logic [3:0]               host_ch;
    logic [ADDR_W-1:0]        host_addr;
    logic [COEF_W-1:0]        host_wdata;
    logic [COEF_W-1:0]        host_rdata;
    // Vector stream
    logic [DATA_W-1:0]        s_vec_tdata;
    logic                     s_vec_tvalid;
    logic                     s_vec_tlast;
    logic                     s_vec_tready;
    // Results
    logic [NUM_CH*DATA_W-1:0] m_result_data;
    logic                     m_result_valid;
    logic                     eigen_update_trig;

    modport master (
        output host_en, host_wren, host_ch, host_addr, host_wdata,
        output s_vec_tdata, s_vec_tvalid, s_vec_tlast,
        input  host_rdata, s_vec_tready,
        input  m_result_data, m_result_valid, eigen_update_trig
    );

    modport slave (
        input  host_en, host_wren, host_ch, host_addr, host_wdata,
        input  s_vec_tdata, s_vec_tvalid, s_vec_tlast,
        output host_rdata, s_vec_tready,
        output m_result_data, m_result_valid, eigen_update_trig
    );
endinterface
`default_nettype wire

// File: rtl/vm_multi_cal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vm_multi_cal
//  Description : NUM_CH parallel signed fixed-point dot products of one
//                streamed vector against per-channel coefficient rows held in
//                dual-port RAM banks. Per-frame clear, saturation, length
//                checking and host read-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module vm_multi_cal #(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 32,
    parameter int FRAC_BITS = 16,
    parameter int ADDR_W    = 9,
    parameter int NUM_CH    = 4,
    // Full headroom for VEC_LEN full-scale products, so saturation always
    // sees the true sum rather than a wrapped one.
    parameter int ACC_W     = DATA_W + COEF_W + ADDR_W
) (
    input  wire              sysClk,
    input  wire              sysRst_n,
    input  wire              enable,
    input  wire [ADDR_W:0]   cfg_len,
    vm_multi_cal_if.slave    bus,
    output logic             err_len,
    output logic [15:0]      frame_cnt
);
    localparam int              c_VEC_LEN    = 1 << ADDR_W;
    localparam int              c_PROD_W     = DATA_W + COEF_W;
    localparam logic [1:0]      c_ST_IDLE    = 2'd0;
    localparam logic [1:0]      c_ST_ACCUM   = 2'd1;
    localparam logic [1:0]      c_ST_DRAIN   = 2'd2;
    localparam logic [1:0]      c_ST_PUBLISH = 2'd3;
    localparam logic [1:0]      c_DRAIN_LAST = 2'd2;
    localparam logic [ADDR_W:0] c_CNT_LAST   = (ADDR_W+1)'(c_VEC_LEN - 1);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]               r_state;
    logic [1:0]               r_drain_cnt;
    logic [ADDR_W:0]          r_cnt;
    logic                     r_ovf;
    logic                     w_ready;
    logic                     w_xfer;
    logic                     w_publish;
    logic                     w_len_bad;
    logic                     w_ch_ok;
    logic                     r_v1;
    logic                     r_first1;
    logic                     r_v2;
    logic                     r_first2;
    logic signed [DATA_W-1:0] r_elem;
    logic                     r_rd_ok;
    logic [3:0]               r_rd_ch;
    logic [COEF_W-1:0]        w_host_rdata;
    logic [NUM_CH*DATA_W-1:0] r_result;
    logic                     r_valid;
    logic                     r_trig;
    wire  [COEF_W-1:0]        w_qa [NUM_CH];
    wire  [NUM_CH*DATA_W-1:0] w_sat;

    assign w_ready   = enable && ((r_state == c_ST_IDLE) || (r_state == c_ST_ACCUM));
    assign w_xfer    = bus.s_vec_tvalid && w_ready;
    assign w_publish = (r_state == c_ST_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);
    assign w_len_bad = r_ovf || (r_cnt != cfg_len);
    assign w_ch_ok   = ({1'b0, bus.host_ch} < 5'(NUM_CH));

    // Frame FSM: accept elements, drain the pipeline for 3 cycles, publish
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            r_state     <= c_ST_IDLE;
            r_drain_cnt <= 2'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_drain_cnt <= 2'd0;
                    if (w_xfer) begin
                        r_state <= bus.s_vec_tlast ? c_ST_DRAIN : c_ST_ACCUM;
                    end
                end
                c_ST_ACCUM: begin
                    r_drain_cnt <= 2'd0;
                    if (w_xfer && bus.s_vec_tlast) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_state <= c_ST_PUBLISH;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Element counter (saturates at VEC_LEN) and overflow flag, cleared per frame
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == c_ST_PUBLISH) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            if (!r_cnt[ADDR_W]) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_cnt == c_CNT_LAST) && !bus.s_vec_tlast) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Pipeline valids: elements past VEC_LEN are accepted but never accumulated
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            r_v1     <= 1'b0;
            r_first1 <= 1'b0;
            r_v2     <= 1'b0;
            r_first2 <= 1'b0;
        end else begin
            r_v1     <= w_xfer && !r_cnt[ADDR_W];
            r_first1 <= (r_state == c_ST_IDLE);
            r_v2     <= r_v1;
            r_first2 <= r_first1;
        end
    end

    // Element register, aligned with the RAM read data
    always_ff @(posedge sysClk) begin
        r_elem <= bus.s_vec_tdata;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [COEF_W-1:0]          r_mem [c_VEC_LEN];
        logic [COEF_W-1:0]          r_qa;
        logic signed [COEF_W-1:0]   r_qb;
        logic signed [c_PROD_W-1:0] r_prod;
        logic signed [ACC_W-1:0]    r_acc;
        logic signed [ACC_W-1:0]    w_ext;
        logic signed [ACC_W-1:0]    w_shift;
        logic [DATA_W-1:0]          w_res;
        logic                       w_sel;

        assign w_sel = (bus.host_ch == 4'(g));

        // Host port A, read-first so a colliding engine read sees old data
        always_ff @(posedge sysClk) begin
            if (bus.host_en && w_sel) begin
                if (bus.host_wren) begin
                    r_mem[bus.host_addr] <= bus.host_wdata;
                end
                r_qa <= r_mem[bus.host_addr];
            end
        end

        // Engine port B: read-only, addressed by the element counter
        always_ff @(posedge sysClk) begin
            r_qb <= r_mem[r_cnt[ADDR_W-1:0]];
        end

        // Signed product of element and coefficient
        always_ff @(posedge sysClk) begin
            r_prod <= r_elem * r_qb;
        end

        assign w_ext = ACC_W'(r_prod);

        // Accumulator: first element of a frame loads instead of adding
        always_ff @(posedge sysClk) begin
            if (!sysRst_n) begin
                r_acc <= '0;
            end else if (r_v2) begin
                r_acc <= r_first2 ? w_ext : (r_acc + w_ext);
            end
        end

        // Drop fractional bits and clamp into the DATA_W range
        always_comb begin
            w_shift = r_acc >>> FRAC_BITS;
            if (w_shift > c_SAT_MAX) begin
                w_res = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (w_shift < c_SAT_MIN) begin
                w_res = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                w_res = w_shift[DATA_W-1:0];
            end
        end

        assign w_sat[g*DATA_W +: DATA_W] = w_res;
        assign w_qa[g] = r_qa;
    end

    // Remember which bank the host read targeted; invalid banks read as 0
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            r_rd_ok <= 1'b0;
            r_rd_ch <= 4'd0;
        end else if (bus.host_en) begin
            r_rd_ok <= w_ch_ok;
            r_rd_ch <= bus.host_ch;
        end
    end

    // Host read-data select
    always_comb begin
        w_host_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_rd_ok && (r_rd_ch == 4'(i))) begin
                w_host_rdata = w_qa[i];
            end
        end
    end

    // Publish results, frame count and length status; trigger follows valid
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_trig    <= 1'b0;
            frame_cnt <= 16'd0;
            err_len   <= 1'b0;
        end else begin
            r_valid <= w_publish;
            r_trig  <= r_valid;
            if (w_publish) begin
                r_result  <= w_sat;
                frame_cnt <= frame_cnt + 16'd1;
                if (w_len_bad) begin
                    err_len <= 1'b1;
                end else if (enable) begin
                    err_len <= 1'b0;
                end
            end
        end
    end

    assign bus.s_vec_tready      = w_ready;
    assign bus.host_rdata        = w_host_rdata;
    assign bus.m_result_data     = r_result;
    assign bus.m_result_valid    = r_valid;
    assign bus.eigen_update_trig = r_trig;
endmodule
`default_nettype wire

// File: tb/tb_vm_multi_cal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vm_multi_cal
//  Description : Directed self-checking bench for vm_multi_cal.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vm_multi_cal;
    localparam int DATA_W    = 32;
    localparam int COEF_W    = 32;
    localparam int FRAC_BITS = 16;
    localparam int ADDR_W    = 9;
    localparam int NUM_CH    = 4;

    logic              sysClk   = 1'b0;
    logic              sysRst_n = 1'b0;
    logic              enable   = 1'b0;
    logic [ADDR_W:0]   cfg_len  = '0;
    logic              err_len;
    logic [15:0]       frame_cnt;
    int                n_checks = 0;
    int                n_errors = 0;
    int                n_pub    = 0;
    logic [DATA_W-1:0] vec [512];

    vm_multi_cal_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) bus ();

    vm_multi_cal #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS),
        .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)
    ) dut (
        .sysClk(sysClk), .sysRst_n(sysRst_n), .enable(enable), .cfg_len(cfg_len),
        .bus(bus), .err_len(err_len), .frame_cnt(frame_cnt)
    );

    always #5 sysClk = ~sysClk;

    always @(negedge sysClk) if (bus.m_result_valid) n_pub++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input int ch, input int addr, input logic [31:0] data);
        @(negedge sysClk);
        bus.host_en = 1'b1; bus.host_wren = 1'b1;
        bus.host_ch = 4'(ch); bus.host_addr = 9'(addr); bus.host_wdata = data;
    endtask

    task automatic host_idle();
        @(negedge sysClk);
        bus.host_en = 1'b0; bus.host_wren = 1'b0;
    endtask

    task automatic host_read(input int ch, input int addr, output logic [31:0] data);
        @(negedge sysClk);
        bus.host_en = 1'b1; bus.host_wren = 1'b0;
        bus.host_ch = 4'(ch); bus.host_addr = 9'(addr);
        @(negedge sysClk);
        data = bus.host_rdata;
        bus.host_en = 1'b0;
    endtask

    // Stream vec[0..n-1]; tlast on element last_idx; tvalid left high at exit
    task automatic send_frame(input int n, input int last_idx, output int stall);
        int guard;
        stall = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge sysClk);
            bus.s_vec_tdata  = vec[i];
            bus.s_vec_tlast  = (i == last_idx);
            bus.s_vec_tvalid = 1'b1;
            guard = 0;
            while (!bus.s_vec_tready && guard < 100) begin
                if (i == 0) stall++;
                @(negedge sysClk);
                guard++;
            end
            if (guard >= 100) chk("tready_wait", bus.s_vec_tready, 1);
            @(posedge sysClk);
        end
    endtask

    // Sample valid/trig in cycles T+1..T+6 after the tlast transfer
    task automatic observe_publish(input bit drop, output logic [5:0] v, output logic [5:0] t);
        for (int k = 0; k < 6; k++) begin
            @(negedge sysClk);
            v[k] = bus.m_result_valid;
            t[k] = bus.eigen_update_trig;
            if (k == 0 && drop) bus.s_vec_tvalid = 1'b0;
        end
    endtask

    task automatic check_results(input string tag, input int mult);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("%s_ch%0d", tag, c), bus.m_result_data[c*DATA_W +: DATA_W], 64'(mult * (c + 1)));
    endtask

    initial begin
        logic [5:0]  v;
        logic [5:0]  t;
        logic [31:0] rd;
        int          stall;
        int          pub0;

        bus.host_en = 0; bus.host_wren = 0; bus.host_ch = 0; bus.host_addr = 0; bus.host_wdata = 0;
        bus.s_vec_tdata = 0; bus.s_vec_tvalid = 0; bus.s_vec_tlast = 0;

        // Reset state
        repeat (3) @(negedge sysClk);
        chk("rst_result", 64'(bus.m_result_data), 0);
        chk("rst_valid", bus.m_result_valid, 0);
        chk("rst_trig", bus.eigen_update_trig, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_tready", bus.s_vec_tready, 0);
        chk("rst_host_rdata", bus.host_rdata, 0);
        sysRst_n = 1'b1;
        enable   = 1'b1;
        cfg_len  = 10'd4;

        // Basic 4-element frame, coef row c = (c+1)<<16
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < 4; a++) host_write(c, a, 32'((c + 1) << 16));
        host_idle();
        for (int i = 0; i < 4; i++) vec[i] = 32'(i + 1);
        send_frame(4, 3, stall);
        observe_publish(1'b1, v, t);
        chk("t1_valid_timing", v, 6'b001000);
        chk("t1_trig_timing", t, 6'b010000);
        check_results("t1_res", 10);
        chk("t1_err_len", err_len, 0);
        chk("t1_frame_cnt", frame_cnt, 1);

        // Full-length saturation, positive then negative
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < 512; a++) host_write(c, a, 32'h7FFF_FFFF);
        host_idle();
        cfg_len = 10'd512;
        for (int i = 0; i < 512; i++) vec[i] = 32'h7FFF_FFFF;
        send_frame(512, 511, stall);
        observe_publish(1'b1, v, t);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("t2_sat_pos_ch%0d", c), bus.m_result_data[c*DATA_W +: DATA_W], 32'h7FFF_FFFF);
        chk("t2_err_len", err_len, 0);
        for (int i = 0; i < 512; i++) vec[i] = 32'h8000_0001;
        send_frame(512, 511, stall);
        observe_publish(1'b1, v, t);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("t2_sat_neg_ch%0d", c), bus.m_result_data[c*DATA_W +: DATA_W], 32'h8000_0000);
        chk("t2_frame_cnt", frame_cnt, 3);

        // Short frame flags err_len; correct-length frame clears it
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < 8; a++) host_write(c, a, 32'((c + 1) << 16));
        host_idle();
        cfg_len = 10'd8;
        for (int i = 0; i < 8; i++) vec[i] = 32'd1;
        send_frame(5, 4, stall);
        observe_publish(1'b1, v, t);
        chk("t3_short_valid", v, 6'b001000);
        check_results("t3_short_res", 5);
        chk("t3_short_err_len", err_len, 1);
        send_frame(8, 7, stall);
        observe_publish(1'b1, v, t);
        check_results("t3_full_res", 8);
        chk("t3_full_err_len", err_len, 0);
        chk("t3_frame_cnt", frame_cnt, 5);

        // Back-to-back frames with tvalid held high
        cfg_len = 10'd4;
        pub0 = n_pub;
        for (int i = 0; i < 4; i++) vec[i] = 32'd100;
        send_frame(4, 3, stall);
        chk("t4_first_stall", stall, 0);
        for (int i = 0; i < 4; i++) vec[i] = 32'd5;
        send_frame(4, 3, stall);
        chk("t4_tready_low_cycles", stall, 4);
        observe_publish(1'b1, v, t);
        chk("t4_valid_timing", v, 6'b001000);
        check_results("t4_res", 20);
        chk("t4_pub_count", n_pub - pub0, 2);
        chk("t4_frame_cnt", frame_cnt, 7);

        // Host write/read-back and invalid bank read
        host_write(2, 9'h1FF, 32'h1234_5678);
        host_idle();
        host_read(2, 9'h1FF, rd);
        chk("t6_host_rd", rd, 32'h1234_5678);
        host_read(7, 9'h1FF, rd);
        chk("t6_host_rd_bad_ch", rd, 0);

        // Reset after 3 elements of a frame
        for (int i = 0; i < 4; i++) vec[i] = 32'(i + 1);
        send_frame(3, 99, stall);
        @(negedge sysClk);
        bus.s_vec_tvalid = 1'b0;
        sysRst_n = 1'b0;
        pub0 = n_pub;
        @(negedge sysClk);
        chk("t5_result", 64'(bus.m_result_data), 0);
        chk("t5_valid", bus.m_result_valid, 0);
        chk("t5_frame_cnt", frame_cnt, 0);
        chk("t5_host_rdata", bus.host_rdata, 0);
        sysRst_n = 1'b1;
        repeat (8) @(negedge sysClk);
        chk("t5_no_publish", n_pub - pub0, 0);
        chk("t5_trig", bus.eigen_update_trig, 0);
        host_read(2, 9'h1FF, rd);
        chk("t5_ram_kept", rd, 32'h1234_5678);
        send_frame(4, 3, stall);
        observe_publish(1'b1, v, t);
        check_results("t5_after_rst_res", 10);
        chk("t5_after_rst_frame_cnt", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
